// File: rtl/group_sum_argmax.sv
// ---------------------------------------------------------------------------
// group_sum_argmax
//
// Multi-cycle classifier readout. One flattened category-bit vector is
// accepted over a valid/ready handshake. Each category's group is popcounted
// CHUNK bits per cycle into a per-category accumulator. The accumulated sums
// are then scanned one category per cycle to find the winner. The result is
// held in output registers until downstream takes it.
//
// Optional feature macro: GROUP_SUM_ARGMAX_MARGIN_EN
//   defined   : second-best tracking is built; out_margin = best - second
//   undefined : no second-best logic; out_margin is tied to 0
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_bits valid
//   in_ready   out  block can accept a vector (high only in IDLE)
//   in_bits    in   CATEGORIES*BITS_PER_CATEGORY bits; category c occupies
//                   [c*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts result
//   out_index  out  winning category (lowest index on ties)
//   out_value  out  winning popcount
//   out_tie    out  another category has the same winning popcount
//   out_margin out  winning sum minus second-best sum (0 on tie)
// ---------------------------------------------------------------------------
module group_sum_argmax #(
    parameter int CATEGORIES        = 10,
    parameter int BITS_PER_CATEGORY = 800,
    parameter int CHUNK             = 32,
    parameter int SUM_W             = $clog2(BITS_PER_CATEGORY + 1),
    parameter int IDX_W             = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] in_bits,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [IDX_W-1:0]                        out_index,
    output logic [SUM_W-1:0]                        out_value,
    output logic                                    out_tie,
    output logic [SUM_W-1:0]                        out_margin
);

    localparam int NCHUNK = (BITS_PER_CATEGORY + CHUNK - 1) / CHUNK;
    // Each group is held zero-padded to a whole number of chunks, so the
    // tail of the last chunk reads as 0 instead of the next group's bits.
    localparam int PAD_W  = NCHUNK * CHUNK;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [K_W-1:0]       k_q;
    logic [IDX_W-1:0]     c_q;
    logic [SUM_W-1:0]     acc_q [CATEGORIES];
    logic [PAD_W-1:0]     grp_q [CATEGORIES];
    logic [SUM_W-1:0]     chunk_cnt [CATEGORIES];

    logic [SUM_W-1:0]     best_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 tie_q;
    logic [SUM_W-1:0]     best_d;
    logic [IDX_W-1:0]     idx_d;
    logic                 tie_d;
    logic [SUM_W-1:0]     cur;

    logic                 out_valid_q;
    logic [IDX_W-1:0]     out_index_q;
    logic [SUM_W-1:0]     out_value_q;
    logic                 out_tie_q;

    logic                 accept;

    // Popcount of one chunk, widened to the accumulator width. CHUNK never
    // exceeds BITS_PER_CATEGORY, so the count always fits in SUM_W bits.
    function automatic logic [SUM_W-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [SUM_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + SUM_W'(v[i]);
        end
        return cnt;
    endfunction

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // Captured vector: a per-group shift register. The low CHUNK bits are
    // always the chunk under count, which avoids a wide variable-index mux.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CATEGORIES; c++) begin
                grp_q[c] <= PAD_W'(in_bits[c*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]);
            end
        end else if (state_q == ACCUM) begin
            for (int c = 0; c < CATEGORIES; c++) begin
                grp_q[c] <= grp_q[c] >> CHUNK;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CATEGORIES; c++) begin
            chunk_cnt[c] = popcnt(grp_q[c][CHUNK-1:0]);
        end
    end

    // Scan step: fold category c_q into the running best/index/tie.
    assign cur = acc_q[c_q];

    always_comb begin
        best_d = best_q;
        idx_d  = idx_q;
        tie_d  = tie_q;
        if (c_q == '0) begin
            best_d = cur;
            idx_d  = '0;
            tie_d  = 1'b0;
        end else if (cur > best_q) begin
            best_d = cur;
            idx_d  = c_q;
            tie_d  = 1'b0;
        end else if (cur == best_q) begin
            tie_d  = 1'b1;
        end
    end

`ifdef GROUP_SUM_ARGMAX_MARGIN_EN
    logic [SUM_W-1:0] second_q;
    logic [SUM_W-1:0] second_d;
    logic [SUM_W-1:0] margin_d;
    logic [SUM_W-1:0] out_margin_q;

    // An equal sum makes the old best the runner-up, which forces the margin
    // to 0 on a tie.
    always_comb begin
        second_d = second_q;
        if (c_q == '0) begin
            second_d = '0;
        end else if (cur > best_q) begin
            second_d = best_q;
        end else if (cur == best_q) begin
            second_d = best_q;
        end else if (cur > second_q) begin
            second_d = cur;
        end
    end

    assign margin_d   = tie_d ? '0 : (best_d - second_d);
    assign out_margin = out_margin_q;
`else
    assign out_margin = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            c_q         <= '0;
            for (int c = 0; c < CATEGORIES; c++) begin
                acc_q[c] <= '0;
            end
            best_q      <= '0;
            idx_q       <= '0;
            tie_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_value_q <= '0;
            out_tie_q   <= 1'b0;
`ifdef GROUP_SUM_ARGMAX_MARGIN_EN
            second_q     <= '0;
            out_margin_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int c = 0; c < CATEGORIES; c++) begin
                            acc_q[c] <= '0;
                        end
                        k_q     <= '0;
                        c_q     <= '0;
                        state_q <= ACCUM;
                    end
                end

                // ACCUM: one chunk of every group per cycle
                ACCUM: begin
                    for (int c = 0; c < CATEGORIES; c++) begin
                        acc_q[c] <= acc_q[c] + chunk_cnt[c];
                    end
                    if (k_q == K_W'(NCHUNK - 1)) begin
                        c_q     <= '0;
                        state_q <= SCAN;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end

                // SCAN: one category per cycle, result loaded on the last one
                SCAN: begin
                    best_q <= best_d;
                    idx_q  <= idx_d;
                    tie_q  <= tie_d;
`ifdef GROUP_SUM_ARGMAX_MARGIN_EN
                    second_q <= second_d;
`endif
                    if (c_q == IDX_W'(CATEGORIES - 1)) begin
                        out_valid_q <= 1'b1;
                        out_index_q <= idx_d;
                        out_value_q <= best_d;
                        out_tie_q   <= tie_d;
`ifdef GROUP_SUM_ARGMAX_MARGIN_EN
                        out_margin_q <= margin_d;
`endif
                        state_q     <= DONE;
                    end else begin
                        c_q <= c_q + IDX_W'(1);
                    end
                end

                // DONE: hold the result until downstream takes it
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_value = out_value_q;
    assign out_tie   = out_tie_q;

endmodule

// File: tb/tb_group_sum_argmax.sv
module tb_group_sum_argmax;

    localparam int NC     = 10;
    localparam int NB     = 800;
    localparam int NCH    = 32;
    localparam int NB_S   = 20;
    localparam int NCH_S  = 8;
    localparam int LAT    = 35;
    localparam int LAT_S  = 13;
    localparam int VW     = NC * NB;
    localparam int VW_S   = NC * NB_S;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [VW-1:0]   in_bits = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [3:0]      out_index;
    logic [9:0]      out_value;
    logic            out_tie;
    logic [9:0]      out_margin;

    logic            in_valid_s = 1'b0;
    logic            in_ready_s;
    logic [VW_S-1:0] in_bits_s = '0;
    logic            out_valid_s;
    logic            out_ready_s = 1'b1;
    logic [3:0]      out_index_s;
    logic [4:0]      out_value_s;
    logic            out_tie_s;
    logic [4:0]      out_margin_s;

    group_sum_argmax #(
        .CATEGORIES(NC), .BITS_PER_CATEGORY(NB), .CHUNK(NCH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_value(out_value),
        .out_tie(out_tie), .out_margin(out_margin)
    );

    group_sum_argmax #(
        .CATEGORIES(NC), .BITS_PER_CATEGORY(NB_S), .CHUNK(NCH_S)
    ) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_bits(in_bits_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_index(out_index_s), .out_value(out_value_s),
        .out_tie(out_tie_s), .out_margin(out_margin_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int val;
        bit tie;
        int margin;
    } exp_t;

    exp_t sbq[$];
    exp_t sbq_s[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference: argmax with lowest-index tie break; runner-up is the largest
    // sum of any other category (equal to best when tied), 0 if none.
    function automatic exp_t model(input logic [VW-1:0] v, input int nb);
        exp_t r;
        int   cnt[NC];
        int   best;
        int   nmax;
        int   second;
        best = -1;
        r.idx = 0;
        for (int c = 0; c < NC; c++) begin
            cnt[c] = 0;
            for (int b = 0; b < nb; b++) cnt[c] += int'(v[c*nb + b]);
            if (cnt[c] > best) begin
                best  = cnt[c];
                r.idx = c;
            end
        end
        nmax = 0;
        second = 0;
        for (int c = 0; c < NC; c++) begin
            if (cnt[c] == best) nmax++;
            if (c != r.idx && cnt[c] > second) second = cnt[c];
        end
        r.val = best;
        r.tie = (nmax > 1);
`ifdef GROUP_SUM_ARGMAX_MARGIN_EN
        r.margin = r.tie ? 0 : best - second;
`else
        r.margin = 0;
`endif
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW/32; w++) v[w*32 +: 32] = $urandom() & $urandom();
        return v;
    endfunction

    // Handshake only: push the expectation and get the vector accepted.
    task automatic apply(input logic [VW-1:0] v);
        sbq.push_back(model(v, NB));
        in_bits  = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_s(input logic [VW_S-1:0] v);
        logic [VW-1:0] w;
        w = '0;
        w[VW_S-1:0] = v;
        sbq_s.push_back(model(w, NB_S));
        in_bits_s  = v;
        in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_out_s(output int n);
        n = 0;
        while (out_valid_s !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_index, out_value, out_tie, out_margin} !== {1'b0, 1'b1, 14'd0, 1'b0, 10'd0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b idx=%0d val=%0d tie=%b margin=%0d, need 0 1 0 0 0 0",
                     out_valid, in_ready, out_index, out_value, out_tie, out_margin);
        end
        n_cmp++;
        if ({out_valid_s, in_ready_s, out_index_s, out_value_s, out_tie_s, out_margin_s} !== {1'b0, 1'b1, 9'd0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_state_small: valid=%b ready=%b idx=%0d val=%0d, need 0 1 0 0",
                     out_valid_s, in_ready_s, out_index_s, out_value_s);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b, need 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero();
        exp_t e;
        int   n;
        apply('0);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy_ready: got %b need 0", in_ready);
        end
        wait_out(n);
        n_cmp++;
        if (n != LAT) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d need %0d", n, LAT);
        end
        e = sbq.pop_front();
        n_cmp++;
        if (out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
            n_fail++;
            $display("FAIL zero_result: idx=%0d val=%0d tie=%b margin=%0d, need idx=%0d val=%0d tie=%b margin=%0d",
                     out_index, out_value, out_tie, out_margin, e.idx, e.val, e.tie, e.margin);
        end
        release_out();
    endtask

    task automatic test_single_cat(input int cat, input string name);
        logic [VW-1:0] v;
        exp_t e;
        int   n;
        v = '0;
        v[cat*NB +: NB] = {NB{1'b1}};
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: got %b need 1", name, in_ready);
        end
        apply(v);
        wait_out(n);
        n_cmp++;
        if (n != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d need %0d", name, n, LAT);
        end
        e = sbq.pop_front();
        n_cmp++;
        if (out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
            n_fail++;
            $display("FAIL %s_result: idx=%0d val=%0d tie=%b margin=%0d, need idx=%0d val=%0d tie=%b margin=%0d",
                     name, out_index, out_value, out_tie, out_margin, e.idx, e.val, e.tie, e.margin);
        end
        release_out();
    endtask

    task automatic test_tie();
        logic [VW-1:0] v;
        exp_t e;
        int   n;
        v = '0;
        for (int c = 0; c < NC; c++) begin
            for (int b = 0; b < ((c == 3 || c == 5) ? 400 : 100); b++) v[c*NB + 2*b + (c & 1)] = 1'b1;
        end
        apply(v);
        wait_out(n);
        e = sbq.pop_front();
        n_cmp++;
        if (n != LAT || out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
            n_fail++;
            $display("FAIL tie_result: lat=%0d idx=%0d val=%0d tie=%b margin=%0d, need lat=%0d idx=%0d val=%0d tie=%b margin=%0d",
                     n, out_index, out_value, out_tie, out_margin, LAT, e.idx, e.val, e.tie, e.margin);
        end
        release_out();
    endtask

    task automatic test_small();
        logic [VW_S-1:0] v;
        exp_t e;
        int   n;
        for (int t = 0; t < 2; t++) begin
            v = '0;
            v[2*NB_S + 16 +: 4] = 4'hF;
            v[0]  = 1'b1;
            v[5]  = 1'b1;
            v[19] = 1'b1;
            if (t == 1) begin
                v[3*NB_S + 0] = 1'b1;
                v[3*NB_S + 1] = 1'b1;
            end
            apply_s(v);
            wait_out_s(n);
            n_cmp++;
            if (n != LAT_S) begin
                n_fail++;
                $display("FAIL small%0d_latency: got %0d need %0d", t, n, LAT_S);
            end
            e = sbq_s.pop_front();
            n_cmp++;
            if (out_index_s !== e.idx[3:0] || out_value_s !== e.val[4:0] || out_tie_s !== e.tie || out_margin_s !== e.margin[4:0]) begin
                n_fail++;
                $display("FAIL small%0d_result: idx=%0d val=%0d tie=%b margin=%0d, need idx=%0d val=%0d tie=%b margin=%0d",
                         t, out_index_s, out_value_s, out_tie_s, out_margin_s, e.idx, e.val, e.tie, e.margin);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        out_ready = 1'b0;
        apply(rand_vec());
        wait_out(n);
        e = sbq.pop_front();
        n_cmp++;
        if (n != LAT || out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
            n_fail++;
            $display("FAIL bp_result: lat=%0d idx=%0d val=%0d tie=%b margin=%0d, need lat=%0d idx=%0d val=%0d tie=%b margin=%0d",
                     n, out_index, out_value, out_tie, out_margin, LAT, e.idx, e.val, e.tie, e.margin);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_bits  = rand_vec();
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== e.idx[3:0] || out_value !== e.val[9:0] ||
                out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b idx=%0d val=%0d tie=%b margin=%0d, need 1 0 %0d %0d %b %0d",
                         i, out_valid, in_ready, out_index, out_value, out_tie, out_margin, e.idx, e.val, e.tie, e.margin);
            end
        end
        // Next vector waits while the result is taken, then goes in a cycle later.
        in_bits = rand_vec();
        sbq.push_back(model(in_bits, NB));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: ready=%b valid=%b, need 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_accept: ready=%b, need 0", in_ready);
        end
        wait_out(n);
        e = sbq.pop_front();
        n_cmp++;
        if (n != LAT || out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
            n_fail++;
            $display("FAIL bp_next_result: lat=%0d idx=%0d val=%0d tie=%b margin=%0d, need lat=%0d idx=%0d val=%0d tie=%b margin=%0d",
                     n, out_index, out_value, out_tie, out_margin, LAT, e.idx, e.val, e.tie, e.margin);
        end
        release_out();
    endtask

    task automatic test_reset_mid_accum();
        in_bits  = rand_vec();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_index, out_value, out_tie, out_margin} !== {1'b0, 1'b1, 14'd0, 1'b0, 10'd0}) begin
            n_fail++;
            $display("FAIL midreset_state: valid=%b ready=%b idx=%0d val=%0d tie=%b margin=%0d, need 0 1 0 0 0 0",
                     out_valid, in_ready, out_index, out_value, out_tie, out_margin);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_single_cat(9, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        exp_t e;
        int   n;
        v1 = rand_vec();
        v2 = rand_vec();
        sbq.push_back(model(v1, NB));
        sbq.push_back(model(v2, NB));
        in_bits  = v1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_bits = v2;
        wait_out(n);
        e = sbq.pop_front();
        n_cmp++;
        if (n != LAT || out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d idx=%0d val=%0d tie=%b margin=%0d, need lat=%0d idx=%0d val=%0d tie=%b margin=%0d",
                     n, out_index, out_value, out_tie, out_margin, LAT, e.idx, e.val, e.tie, e.margin);
        end
        @(posedge clk); #1;
        wait_out(n);
        in_valid = 1'b0;
        n_cmp++;
        if (n + 1 != LAT + 2) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d need %0d", n + 1, LAT + 2);
        end
        e = sbq.pop_front();
        n_cmp++;
        if (out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
            n_fail++;
            $display("FAIL b2b_second: idx=%0d val=%0d tie=%b margin=%0d, need idx=%0d val=%0d tie=%b margin=%0d",
                     out_index, out_value, out_tie, out_margin, e.idx, e.val, e.tie, e.margin);
        end
        release_out();
    endtask

    task automatic test_random();
        exp_t e;
        int   n;
        for (int t = 0; t < 4; t++) begin
            apply(rand_vec());
            wait_out(n);
            e = sbq.pop_front();
            n_cmp++;
            if (n != LAT || out_index !== e.idx[3:0] || out_value !== e.val[9:0] || out_tie !== e.tie || out_margin !== e.margin[9:0]) begin
                n_fail++;
                $display("FAIL random%0d: lat=%0d idx=%0d val=%0d tie=%b margin=%0d, need lat=%0d idx=%0d val=%0d tie=%b margin=%0d",
                         t, n, out_index, out_value, out_tie, out_margin, LAT, e.idx, e.val, e.tie, e.margin);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_cat(7, "cat7");
        test_tie();
        test_small();
        test_backpressure();
        test_reset_mid_accum();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/group_sum_argmax.md
# group_sum_argmax

Parametrised, multi-cycle classifier readout for the logic-gate network. It sits after the registered `categories` bus of `net`. It accepts one flattened category-bit vector through a valid/ready handshake and popcounts each category's group `CHUNK` bits per cycle, so no single wide adder tree is needed. It then scans the category sums sequentially and returns the winning index, the winning sum, a tie flag and, optionally, the best-minus-second margin, holding the result until downstream consumes it.

## Interface
Parameters:
- `CATEGORIES`, 10, number of classes; must be ≥1.
- `BITS_PER_CATEGORY`, 800, bits per class group; must be ≥1.
- `CHUNK`, 32, bits per group popcounted per cycle; 1..`BITS_PER_CATEGORY`; need not divide `BITS_PER_CATEGORY`.
- `SUM_W`, `$clog2(BITS_PER_CATEGORY+1)`, width of sums, value and margin.
- `IDX_W`, `$clog2(CATEGORIES)` (min 1), index width.

Ports:
- `clk`, in, 1, clock.
- `rst_n`, in, 1, reset. One clock; reset is asynchronous and active-low.
- `in_valid`, in, 1, `in_bits` valid.
- `in_ready`, out, 1, block can accept; equals (state==IDLE).
- `in_bits`, in, `CATEGORIES*BITS_PER_CATEGORY`, category c occupies `[c*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]`.
- `out_valid`, out, 1, result valid.
- `out_ready`, in, 1, downstream accepts result.
- `out_index`, out, `IDX_W`, winning category.
- `out_value`, out, `SUM_W`, winning popcount.
- `out_tie`, out, 1, another category equals the winning sum.
- `out_margin`, out, `SUM_W`, winning sum minus second-best sum.

## Operation
- FSM states: IDLE → ACCUM → SCAN → DONE → IDLE.
- IDLE:
  - On `in_valid && in_ready`, capture `in_bits` into an internal register.
  - Clear all `CATEGORIES` accumulators and the chunk counter `k`.
  - Go to ACCUM.
- ACCUM, one cycle per chunk, `NCHUNK = ceil(BITS_PER_CATEGORY/CHUNK)` cycles:
  - Each cycle, every accumulator adds the popcount of bits `[k*CHUNK +: CHUNK]` of its group.
  - Bits at or above `BITS_PER_CATEGORY` in the last chunk are masked to 0.
  - After `k==NCHUNK-1`, go to SCAN.
- SCAN, one category per cycle, c = 0..`CATEGORIES-1`:
  - c=0: best=acc[0], idx=0, second=0, tie=0.
  - Otherwise, apply the first matching rule:
    - acc[c]>best: second=best, best=acc[c], idx=c, tie=0.
    - acc[c]==best: tie=1, second=best.
    - acc[c]>second: second=acc[c].
  - Ties resolve to the lowest index.
  - After c=`CATEGORIES-1`, load the output registers and go to DONE.
- DONE:
  - `out_valid`=1; outputs stay stable.
  - On `out_ready`, go to IDLE.
  - An `in_valid` in the same cycle is not accepted, because `in_ready`=0.
- Output registers hold the last result after the handshake, until the next SCAN completes.
- Arithmetic:
  - Accumulators are `SUM_W` wide and cannot overflow.
  - Margin = best − second, never negative.
  - Margin is 0 when tie=1.
  - With `CATEGORIES`=1, margin = best.
- Reset:
  - Asserting `rst_n` low at any time forces IDLE and zeroes the accumulators, `k`, c and all outputs.
  - The captured vector is discarded; no partial result is ever presented.

## Timing
- Reset values:
  - `out_valid`=0, `out_index`=0, `out_value`=0, `out_tie`=0, `out_margin`=0.
  - `in_ready`=1, since the block is in IDLE.
- Latency: `out_valid` rises `NCHUNK+CATEGORIES` cycles after the accepting edge; 35 cycles with the defaults.
- Throughput: one vector per `NCHUNK+CATEGORIES+2` cycles with `out_ready` held high. The extra two cycles are the DONE cycle and the IDLE accept cycle.
- `in_ready` is low in ACCUM, SCAN and DONE. `in_bits` may change freely after acceptance.
- `out_valid` stays high and outputs stay stable until `out_ready` is sampled high.

## Configuration
- Macro: `GROUP_SUM_ARGMAX_MARGIN_EN`.
- Defined: second-best tracking is built and `out_margin` carries best − second.
- Undefined: no second-best register or subtractor is built, and `out_margin` is tied to 0.
- `out_tie`, `out_index` and `out_value` behave identically in both builds.

## Test plan
- All-zero vector, default parameters, `out_ready`=1 → `out_valid` 35 cycles after accept; index 0, value 0, tie 1, margin 0.
- Category 7 all ones, others zero → index 7, value 800, tie 0, margin 800 (0 without the macro).
- Categories 3 and 5 at 400 set bits, others at 100 → index 3, value 400, tie 1, margin 0.
- `BITS_PER_CATEGORY`=20, `CHUNK`=8; category 2 has only bits 16..19 set, category 0 has 3 bits → index 2, value 4, margin 1; latency 3+10=13 cycles.
- `out_ready` held low for 20 cycles in DONE while `in_valid` pulses → outputs stable, `in_ready`=0, nothing accepted. After `out_ready`, the next vector is accepted one cycle later.
- `rst_n` pulsed low mid-ACCUM → all outputs 0 and `in_ready`=1 immediately. The next vector (category 9 all ones) yields index 9, value 800 at the nominal latency.
